uart_cmd_ctrl: RTL
==================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command/config controller between the UART receiver and the modulator/TX datapath.
//  Parses 3-byte frames {SYNC=8'h3F, ADDR, DATA} from the RX byte stream and writes a small register file (MODE, BPS, MESSAGE, CTRL).
//  Sequences datapath runs with a start/busy/done handshake; supports single-shot and continuous runs.
// PARAMETERS
//  MESSAGE_SIZE  1      width of out_message (1..8)
//  BPS_RESET     24     reset value of out_bps
//  CLKS_PER_BIT  640    UART bit period in in_clk cycles
//  TIMEOUT_CLKS  14080  inter-byte gap that aborts a partial frame (22 bit periods)
// PORTS
//  in_clk       in   1             system clock (73.728 MHz)
//  in_reset     in   1             synchronous, active-high reset
//  in_rx_byte   in   8             received UART byte
//  in_rx_valid  in   1             1-cycle strobe, in_rx_byte valid
//  in_mode      in   2             mode pins; used when CTRL.SRC=0
//  in_dp_busy   in   1             datapath running
//  in_dp_done   in   1             1-cycle strobe, datapath run finished
//  out_mode     out  2             effective mode to datapath
//  out_bps      out  8             bits-per-symbol config
//  out_message  out  MESSAGE_SIZE  message word to datapath
//  out_dp_start out  1             1-cycle start strobe
//  out_frame_err out 1             1-cycle strobe: bad ADDR or timeout
// BEHAVIOUR
//  Reset: mode_reg=0, out_bps=BPS_RESET, out_message=0, CTRL=0, out_dp_start=0, out_frame_err=0; parser HUNT, sequencer IDLE, pending=0.
//  Parser FSM: HUNT -(valid & byte==3F)-> GOT_SYNC -(valid)-> GOT_ADDR (latch ADDR) -(valid)-> commit write, back to HUNT.
//   - In HUNT non-3F bytes are discarded silently. In GOT_SYNC/GOT_ADDR a 3F byte is ordinary data (no resync).
//   - Gap counter clears on each valid byte; reaching TIMEOUT_CLKS in GOT_SYNC/GOT_ADDR -> HUNT, out_frame_err pulse.
//   - Write commits on the cycle after the DATA strobe; registers update in that same cycle.
//  Register map: 00 MODE[1:0]; 01 BPS[7:0]; 02 MESSAGE[MESSAGE_SIZE-1:0] (upper bits dropped);
//   03 CTRL: bit0 START (self-clearing), bit1 SRC (1 = out_mode from MODE reg, 0 = in_mode), bit4 CONT; other bits ignored.
//   ADDR >= 04: no write, out_frame_err pulse, parser HUNT.
//  out_mode is combinational mux of SRC (registered inputs only).
//  Sequencer FSM: IDLE -> START -> RUN -> IDLE.
//   - IDLE: start request (START write or pending) & !in_dp_busy -> out_dp_start=1 for exactly one cycle, go RUN.
//   - START write while busy or in RUN: set pending (1-deep; further requests merge).
//   - RUN: on in_dp_done -> if CONT or pending: clear pending, re-issue start in next cycle; else IDLE.
//   - CONT cleared mid-run: current run completes, no restart.
//   - in_dp_done outside RUN is ignored.
//  Config writes (MODE/BPS/MESSAGE) during RUN take effect immediately; datapath samples them at start.
//  Simultaneous in_rx_valid and timeout: byte wins (counter cleared, no error).
//  Reset mid-frame or mid-run: all state to reset values in one cycle; no start strobe issued.
// CONFIGURATION
//  UART_CMD_ECHO_EN defined: adds out_tx_byte[7:0], out_tx_valid, in_tx_ready; after each committed write
//   an ack byte {4'hA, ADDR[3:0]} is held valid until in_tx_ready; after out_frame_err sends 8'hEE.
//   One-entry buffer; a new ack while full overwrites it.
//  Not defined: ports absent, no ack logic; behaviour otherwise identical.
// STRUCTURE
//  Package uart_cmd_pkg: SYNC_BYTE=8'h3F, register address constants, CTRL bit indices, parser/sequencer state enums, ACK/NAK constants.
//  Sub-module uart_cmd_seq: sequencer FSM (start/pending/cont); parser and register file stay in top.
// TESTING
//  Bytes 3F,00,03 then 3F,03,02 -> out_mode=2'b11 after 2nd frame; in_mode ignored.
//  3F,03,01 with in_dp_busy=0 -> out_dp_start high exactly 1 cycle; after in_dp_done -> IDLE, no restart.
//  3F,03,33 -> start pulse; each in_dp_done -> new start next cycle until 3F,03,02 written; then no restart after done.
//  3F,03,01 twice during RUN -> exactly one additional start after done (pending merge).
//  3F,05,AA -> out_frame_err pulse, no register change; 3F,01 then 14080-cycle gap -> out_frame_err, next 3F,01,10 -> out_bps=8'h10.
//  Reset asserted between ADDR and DATA -> parser HUNT, all outputs at reset values; with UART_CMD_ECHO_EN, 3F,01,10 -> ack byte 8'hA1.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants, state enums and ack helper for the UART command controller
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'h3F;
  localparam logic [7:0] ADDR_MODE  = 8'h00;
  localparam logic [7:0] ADDR_BPS   = 8'h01;
  localparam logic [7:0] ADDR_MSG   = 8'h02;
  localparam logic [7:0] ADDR_CTRL  = 8'h03;
  localparam logic [7:0] ADDR_LIMIT = 8'h04;

  localparam int CTRL_START = 0;
  localparam int CTRL_SRC   = 1;
  localparam int CTRL_CONT  = 4;

  localparam logic [3:0] ACK_NIBBLE = 4'hA;
  localparam logic [7:0] NAK_BYTE   = 8'hEE;

  typedef enum logic [1:0] {
    P_HUNT,
    P_SYNC,
    P_ADDR
  } parse_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN
  } seq_state_e;

  function automatic logic [7:0] ack_byte(input logic [7:0] addr);
    return {ACK_NIBBLE, addr[3:0]};
  endfunction

endpackage

// File: rtl/uart_cmd_seq.sv
// rtl/uart_cmd_seq.sv - datapath run sequencer: start strobe, 1-deep pending request, continuous restart
module uart_cmd_seq
  import uart_cmd_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_req_i,
  input  logic cont_i,
  input  logic dp_busy_i,
  input  logic dp_done_i,
  output logic dp_start_o
);

  seq_state_e state_q, state_d;
  logic       pending_q, pending_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Any request not consumed this cycle collapses into the single pending flag.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | start_req_i;
    dp_start_o = (state_q == S_START);
    case (state_q)
      S_IDLE: begin
        if ((start_req_i || pending_q) && !dp_busy_i) begin
          state_d   = S_START;
          pending_d = 1'b0;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (dp_done_i) begin
          if (cont_i || pending_q || start_req_i) begin
            state_d   = S_START;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - frame parser and register file for the UART command path
// Optional ack/nak echo channel enabled by UART_CMD_ECHO_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int MESSAGE_SIZE = 1,
  parameter int BPS_RESET    = 24,
  parameter int CLKS_PER_BIT = 640,
  parameter int TIMEOUT_CLKS = 14080
) (
  input  logic                    in_clk,
  input  logic                    in_reset,
  input  logic [7:0]              in_rx_byte,
  input  logic                    in_rx_valid,
  input  logic [1:0]              in_mode,
  input  logic                    in_dp_busy,
  input  logic                    in_dp_done,
`ifdef UART_CMD_ECHO_EN
  output logic [7:0]              out_tx_byte,
  output logic                    out_tx_valid,
  input  logic                    in_tx_ready,
`endif
  output logic [1:0]              out_mode,
  output logic [7:0]              out_bps,
  output logic [MESSAGE_SIZE-1:0] out_message,
  output logic                    out_dp_start,
  output logic                    out_frame_err
);

  localparam int GAP_MAX = (TIMEOUT_CLKS > CLKS_PER_BIT) ? TIMEOUT_CLKS : CLKS_PER_BIT;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  parse_state_e            pstate_q, pstate_d;
  logic [7:0]              addr_q, addr_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    wr_en, err_d;
  logic [1:0]              mode_q, in_mode_q;
  logic [7:0]              bps_q;
  logic [MESSAGE_SIZE-1:0] msg_q;
  logic                    src_q, cont_q, start_q, err_q;
  logic                    timeout;

  assign timeout = (gap_q == GAP_W'(TIMEOUT_CLKS - 1));

  always_comb begin
    pstate_d = pstate_q;
    addr_d   = addr_q;
    gap_d    = '0;
    wr_en    = 1'b0;
    err_d    = 1'b0;
    case (pstate_q)
      P_HUNT: begin
        if (in_rx_valid && in_rx_byte == SYNC_BYTE) pstate_d = P_SYNC;
      end
      P_SYNC, P_ADDR: begin
        if (in_rx_valid) begin
          if (pstate_q == P_SYNC) begin
            addr_d   = in_rx_byte;
            pstate_d = P_ADDR;
          end else begin
            pstate_d = P_HUNT;
            wr_en    = (addr_q < ADDR_LIMIT);
            err_d    = (addr_q >= ADDR_LIMIT);
          end
        end else if (timeout) begin
          pstate_d = P_HUNT;
          err_d    = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: pstate_d = P_HUNT;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      pstate_q  <= P_HUNT;
      addr_q    <= '0;
      gap_q     <= '0;
      mode_q    <= '0;
      in_mode_q <= '0;
      bps_q     <= 8'(BPS_RESET);
      msg_q     <= '0;
      src_q     <= 1'b0;
      cont_q    <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pstate_q  <= pstate_d;
      addr_q    <= addr_d;
      gap_q     <= gap_d;
      in_mode_q <= in_mode;
      err_q     <= err_d;
      start_q   <= wr_en && (addr_q == ADDR_CTRL) && in_rx_byte[CTRL_START];
      if (wr_en) begin
        case (addr_q)
          ADDR_MODE: mode_q <= in_rx_byte[1:0];
          ADDR_BPS:  bps_q  <= in_rx_byte;
          ADDR_MSG:  msg_q  <= in_rx_byte[MESSAGE_SIZE-1:0];
          ADDR_CTRL: begin
            src_q  <= in_rx_byte[CTRL_SRC];
            cont_q <= in_rx_byte[CTRL_CONT];
          end
          default: ;
        endcase
      end
    end
  end

  assign out_mode      = src_q ? mode_q : in_mode_q;
  assign out_bps       = bps_q;
  assign out_message   = msg_q;
  assign out_frame_err = err_q;

`ifdef UART_CMD_ECHO_EN
  logic [7:0] tx_byte_q;
  logic       tx_valid_q;

  // A fresh ack/nak replaces whatever is still waiting in the single slot.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
    end else if (wr_en) begin
      tx_byte_q  <= ack_byte(addr_q);
      tx_valid_q <= 1'b1;
    end else if (err_d) begin
      tx_byte_q  <= NAK_BYTE;
      tx_valid_q <= 1'b1;
    end else if (tx_valid_q && in_tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign out_tx_byte  = tx_byte_q;
  assign out_tx_valid = tx_valid_q;
`endif

  uart_cmd_seq u_seq (
    .clk_i       (in_clk),
    .reset_i     (in_reset),
    .start_req_i (start_q),
    .cont_i      (cont_q),
    .dp_busy_i   (in_dp_busy),
    .dp_done_i   (in_dp_done),
    .dp_start_o  (out_dp_start)
  );

endmodule
